mem_access_ctrl: RTL and testbench

//  Bus controller between the CPU core and the synchronous byte-wide memory block.

---
 rtl/mem_access_ctrl_pkg.sv | 39 +++
 rtl/mem_access_ctrl.sv | 147 ++++++++++++++
 tb/tb_mem_access_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_ctrl_pkg
// Purpose  : Shared definitions for the memory access controller: 3-bit
//            state encoding, little-endian byte-lane constants and a lane
//            select helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package mem_access_ctrl_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RD0  = 3'd1;
  localparam logic [2:0] ST_RD1  = 3'd2;
  localparam logic [2:0] ST_RD2  = 3'd3;
  localparam logic [2:0] ST_WR0  = 3'd4;
  localparam logic [2:0] ST_WR1  = 3'd5;
  localparam logic [2:0] ST_RESP = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE = ST_IDLE,
    S_RD0  = ST_RD0,
    S_RD1  = ST_RD1,
    S_RD2  = ST_RD2,
    S_WR0  = ST_WR0,
    S_WR1  = ST_WR1,
    S_RESP = ST_RESP
  } state_t;

  // Little-endian lanes: low byte lives at A, high byte at A+1.
  localparam logic LANE_LO = 1'b0;
  localparam logic LANE_HI = 1'b1;

  function automatic logic [7:0] byte_lane(input logic [15:0] data, input logic lane);
    return (lane == LANE_HI) ? data[15:8] : data[7:0];
  endfunction

endpackage : mem_access_ctrl_pkg
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_ctrl
// Purpose  : Sequences byte / 16-bit word core requests into byte-wide
//            transactions on a synchronous memory with a registered output.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            req, we, word       - request strobe, write, 16-bit access
//            addr, wdata         - byte address (low byte), write data
//            rdata, busy, done   - read result, not-idle flag, completion pulse
//            mem_addr, mem_wdata - memory address / write byte
//            mem_rdata           - memory registered read data
//            mem_ce, mem_r, mem_w, mem_oe - memory strobes
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic              word,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       wdata,
  output logic [15:0]       rdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              mem_ce,
  output logic              mem_r,
  output logic              mem_w,
  output logic              mem_oe
);

  state_t              r_state;
  state_t              w_state_next;
  logic                r_word;
  logic [ADDR_W-1:0]   r_addr;
  logic [15:0]         r_wdata;
  logic [15:0]         r_rdata;
  logic [ADDR_W-1:0]   w_addr_hi;

  // Second byte address; the carry out of the top bit is dropped so that a
  // word at the last address wraps to address 0.
  assign w_addr_hi = r_addr + {{(ADDR_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_word  <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == S_IDLE && req) begin
        r_word  <= word;
        r_addr  <= addr;
        r_wdata <= wdata;
      end
      // Memory data captured during RD0's edge is visible in RD1, and the
      // A+1 byte issued in RD1 is visible in RD2.
      if (r_state == S_RD1) begin
        r_rdata[7:0] <= mem_rdata;
        if (!r_word) begin
          r_rdata[15:8] <= 8'h00;
        end
      end
      if (r_state == S_RD2) begin
        r_rdata[15:8] <= mem_rdata;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    done         = 1'b0;
    mem_ce       = 1'b0;
    mem_r        = 1'b0;
    mem_w        = 1'b0;
    mem_oe       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = 8'h00;
    case (r_state)
      S_IDLE: begin
        if (req) begin
          w_state_next = we ? S_WR0 : S_RD0;
        end
      end
      S_RD0: begin
        mem_ce       = 1'b1;
        mem_r        = 1'b1;
        mem_addr     = r_addr;
        w_state_next = S_RD1;
      end
      S_RD1: begin
        mem_ce = 1'b1;
        mem_oe = 1'b1;
        if (r_word) begin
          // Overlap the high-byte fetch with the low-byte capture.
          mem_r        = 1'b1;
          mem_addr     = w_addr_hi;
          w_state_next = S_RD2;
        end else begin
          mem_addr     = r_addr;
          w_state_next = S_RESP;
        end
      end
      S_RD2: begin
        mem_ce       = 1'b1;
        mem_oe       = 1'b1;
        mem_addr     = w_addr_hi;
        w_state_next = S_RESP;
      end
      S_WR0: begin
        mem_ce       = 1'b1;
        mem_w        = 1'b1;
        mem_addr     = r_addr;
        mem_wdata    = byte_lane(r_wdata, LANE_LO);
        w_state_next = r_word ? S_WR1 : S_RESP;
      end
      S_WR1: begin
        mem_ce       = 1'b1;
        mem_w        = 1'b1;
        mem_addr     = w_addr_hi;
        mem_wdata    = byte_lane(r_wdata, LANE_HI);
        w_state_next = S_RESP;
      end
      S_RESP: begin
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign busy  = (r_state != S_IDLE);
  assign rdata = r_rdata;

endmodule : mem_access_ctrl
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_ctrl
// Purpose  : Self-checking bench for mem_access_ctrl with a 64K byte memory
//            model. Requests push their expected response into a queue; a
//            monitor pops and compares on every done pulse and also checks
//            strobe protocol every cycle.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_ctrl;

  localparam int ADDR_W = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req = 1'b0;
  logic              we = 1'b0;
  logic              word = 1'b0;
  logic [15:0]       addr = '0;
  logic [15:0]       wdata = '0;
  logic [15:0]       rdata;
  logic              busy;
  logic              done;
  logic [15:0]       mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic              mem_ce, mem_r, mem_w, mem_oe;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    bit          is_wr;
    bit          wd;
    logic [15:0] a;
    logic [15:0] d;
    logic [15:0] exp_rd;
    int          due;
  } item_t;

  item_t q[$];

  mem_access_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .word(word), .addr(addr),
    .wdata(wdata), .rdata(rdata), .busy(busy), .done(done),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ce(mem_ce), .mem_r(mem_r), .mem_w(mem_w), .mem_oe(mem_oe)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous memory: registered read, data shown while ce & oe.
  logic [7:0] mem [0:65535];
  logic [7:0] mem_reg = 8'h00;
  initial for (int i = 0; i < 65536; i++) mem[i] = i[7:0] ^ 8'h5A;
  always @(posedge clk) begin
    if (mem_ce && mem_w) mem[mem_addr] <= mem_wdata;
    if (mem_ce && mem_r) mem_reg <= mem[mem_addr];
  end
  assign mem_rdata = (mem_ce && mem_oe) ? mem_reg : 8'h00;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic int lat(input bit w, input bit wd);
    if (w) return wd ? 3 : 2;
    return wd ? 4 : 3;
  endfunction

  // Monitor: protocol every cycle, scoreboard pop on done.
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      chk("r_w_exclusive", {31'd0, mem_r & mem_w}, 32'd0);
      chk("oe_only_in_read", {31'd0, mem_oe & ~(mem_ce & busy & ~mem_w)}, 32'd0);
      chk("done_width", {31'd0, done & prev_done}, 32'd0);
      if (!busy)
        chk("idle_mem_outputs", {6'd0, mem_ce, mem_r, mem_w, mem_oe, mem_addr, mem_wdata}, 32'd0);
      if (done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          item_t it;
          logic [15:0] a1;
          it = q.pop_front();
          a1 = it.a + 16'd1;
          chk("done_latency", it.due, cyc);
          chk("rdata", {16'd0, rdata}, {16'd0, it.exp_rd});
          if (it.is_wr) begin
            chk("mem_lo", {24'd0, mem[it.a]}, {24'd0, it.d[7:0]});
            if (it.wd) chk("mem_hi", {24'd0, mem[a1]}, {24'd0, it.d[15:8]});
          end
        end
      end
      prev_done = done;
    end else begin
      prev_done = 1'b0;
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      chk("done_timeout", q.size(), 32'd0);
      q.delete();
    end
  endtask

  // Issue one request from IDLE and queue its expected response.
  task automatic issue(input bit w, input bit wd, input logic [15:0] a,
                       input logic [15:0] d, input logic [15:0] exp_rd);
    item_t it;
    wait_idle();
    we = w; word = wd; addr = a; wdata = d; req = 1'b1;
    it.is_wr = w; it.wd = wd; it.a = a; it.d = d; it.exp_rd = exp_rd;
    it.due = cyc + lat(w, wd);
    q.push_back(it);
    @(negedge clk);
    req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    item_t it;
    int c;
    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_rdata", {16'd0, rdata}, 32'd0);
    chk("reset_mem_outs", {6'd0, mem_ce, mem_r, mem_w, mem_oe, mem_addr, mem_wdata}, 32'd0);
    rst = 1'b0;

    // Reset in the middle of a word read: no done, everything back to zero
    wait_idle();
    we = 1'b0; word = 1'b1; addr = 16'h0030; req = 1'b1;
    @(negedge clk); req = 1'b0;       // RD0
    @(negedge clk); rst = 1'b1;       // RD1
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_mem_outs", {6'd0, mem_ce, mem_r, mem_w, mem_oe, mem_addr, mem_wdata}, 32'd0);
    chk("midrst_rdata", {16'd0, rdata}, 32'd0);
    repeat (6) @(negedge clk);

    // Word write / read, byte write / read with zero-extension
    issue(1'b1, 1'b1, 16'h0020, 16'hBEEF, 16'h0000); wait_drain();
    issue(1'b0, 1'b1, 16'h0020, 16'h0000, 16'hBEEF); wait_drain();
    issue(1'b1, 1'b0, 16'h0010, 16'h00A5, 16'hBEEF); wait_drain();
    issue(1'b0, 1'b0, 16'h0010, 16'h0000, 16'h00A5); wait_drain();
    issue(1'b0, 1'b0, 16'h0021, 16'h0000, 16'h00BE); wait_drain();

    // Address wrap on a word at the last address
    issue(1'b1, 1'b1, 16'hFFFF, 16'h1234, 16'h00BE); wait_drain();
    chk("wrap_mem0", {24'd0, mem[0]}, 32'h12);
    issue(1'b0, 1'b1, 16'hFFFF, 16'h0000, 16'h1234); wait_drain();

    // Byte write ignores wdata[15:8]; neighbouring byte keeps 0x51^0x5A
    issue(1'b1, 1'b0, 16'h0050, 16'h77C3, 16'h1234); wait_drain();
    chk("byte_wr_neighbour", {24'd0, mem[16'h0051]}, 32'h0B);

    // Request pulsed while busy (RD1) is dropped
    issue(1'b0, 1'b1, 16'h0020, 16'h0000, 16'hBEEF);   // returns in RD0
    @(negedge clk);                                    // RD1
    we = 1'b1; word = 1'b0; addr = 16'h0040; wdata = 16'h00FF; req = 1'b1;
    @(negedge clk); req = 1'b0;
    wait_drain();
    repeat (6) @(negedge clk);
    chk("ignored_write", {24'd0, mem[16'h0040]}, 32'h1A);

    // req held: back-to-back accepts one idle cycle apart
    wait_idle();
    c = cyc;
    we = 1'b0; word = 1'b0; addr = 16'h0010; req = 1'b1;
    it.is_wr = 1'b0; it.wd = 1'b0; it.a = 16'h0010; it.d = 16'h0000; it.exp_rd = 16'h00A5;
    it.due = c + 3; q.push_back(it);
    it.due = c + 7; q.push_back(it);
    repeat (5) @(negedge clk);
    req = 1'b0;
    wait_drain();
    repeat (6) @(negedge clk);

    chk("queue_empty", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_mem_access_ctrl
`default_nettype wire
